// File: rtl/mux_sel_sequencer.sv
// Captures a word over valid/ready and walks the mux select across it; first bit one cycle after accept.
// load_ready only in IDLE (or on the last bit when GAP_CYCLES=0, for bubble-free back-to-back frames).
module mux_sel_sequencer #(
   parameter int DATA_W     = 8,
   parameter int SEL_W      = $clog2(DATA_W),
   parameter bit MSB_FIRST  = 1'b0,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic [DATA_W-1:0] mux_d,
   output logic [SEL_W-1:0]  mux_sel,
   output logic              ser_bit,
   output logic              ser_valid,
   output logic              frame_start,
   output logic              frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
   localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);
   localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

   state_t              r_state;
   logic [DATA_W-1:0]   r_mux_d;
   logic [SEL_W-1:0]    r_mux_sel;
   logic                r_ser_valid;
   logic                r_frame_start;
   logic                r_frame_done;
   logic [3:0]          r_gap_cnt;

   state_t              w_state_nxt;
   logic [DATA_W-1:0]   w_mux_d_nxt;
   logic [SEL_W-1:0]    w_mux_sel_nxt;
   logic                w_ser_valid_nxt;
   logic                w_frame_start_nxt;
   logic                w_frame_done_nxt;
   logic [3:0]          w_gap_cnt_nxt;
   logic [SEL_W-1:0]    w_sel_step;
   logic                w_load_ready;
   logic                w_accept;

   // Ready is a pure register decode, so a producer never sees a combinational loop through us.
   assign w_load_ready = (r_state == ST_IDLE) ||
                         ((GAP_CYCLES == 0) && (r_state == ST_SHIFT) && r_frame_done);
   assign w_accept     = load_valid && w_load_ready;
   assign w_sel_step   = MSB_FIRST ? (r_mux_sel - SEL_ONE) : (r_mux_sel + SEL_ONE);

   always_comb begin
      w_state_nxt       = r_state;
      w_mux_d_nxt       = r_mux_d;
      w_mux_sel_nxt     = '0;
      w_ser_valid_nxt   = 1'b0;
      w_frame_start_nxt = 1'b0;
      w_frame_done_nxt  = 1'b0;
      w_gap_cnt_nxt     = r_gap_cnt;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt       = ST_SHIFT;
               w_mux_d_nxt       = load_data;
               w_mux_sel_nxt     = SEL_FIRST;
               w_ser_valid_nxt   = 1'b1;
               w_frame_start_nxt = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (!r_frame_done) begin
               w_mux_sel_nxt    = w_sel_step;
               w_ser_valid_nxt  = 1'b1;
               w_frame_done_nxt = (w_sel_step == SEL_LAST);
            end else if (w_accept) begin
               w_mux_d_nxt       = load_data;
               w_mux_sel_nxt     = SEL_FIRST;
               w_ser_valid_nxt   = 1'b1;
               w_frame_start_nxt = 1'b1;
            end else if (GAP_CYCLES == 0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt   = ST_GAP;
               w_gap_cnt_nxt = '0;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nxt   = ST_IDLE;
               w_gap_cnt_nxt = '0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_mux_d       <= '0;
         r_mux_sel     <= '0;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_gap_cnt     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_mux_d       <= w_mux_d_nxt;
         r_mux_sel     <= w_mux_sel_nxt;
         r_ser_valid   <= w_ser_valid_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_frame_done  <= w_frame_done_nxt;
         r_gap_cnt     <= w_gap_cnt_nxt;
      end
   end

   assign load_ready  = w_load_ready;
   assign mux_d       = r_mux_d;
   assign mux_sel     = r_mux_sel;
   assign ser_bit     = r_ser_valid & r_mux_d[r_mux_sel];
   assign ser_valid   = r_ser_valid;
   assign frame_start = r_frame_start;
   assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench: three sequencer variants (LSB-first/no gap, MSB-first, 3-cycle gap) and a reference 8:1 mux.
module tb_mux_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       lv_a, lr_a, sb_a, sv_a, fs_a, fd_a;
   logic [7:0] ld_a, md_a;
   logic [2:0] ms_a;

   logic       lv_m, lr_m, sb_m, sv_m, fs_m, fd_m;
   logic [7:0] ld_m, md_m;
   logic [2:0] ms_m;

   logic       lv_g, lr_g, sb_g, sv_g, fs_g, fd_g;
   logic [7:0] ld_g, md_g;
   logic [2:0] ms_g;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_sel_sequencer #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_data(ld_a), .load_ready(lr_a),
      .mux_d(md_a), .mux_sel(ms_a), .ser_bit(sb_a), .ser_valid(sv_a),
      .frame_start(fs_a), .frame_done(fd_a));

   mux_sel_sequencer #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
      .clk(clk), .rst_n(rst_n), .load_valid(lv_m), .load_data(ld_m), .load_ready(lr_m),
      .mux_d(md_m), .mux_sel(ms_m), .ser_bit(sb_m), .ser_valid(sv_m),
      .frame_start(fs_m), .frame_done(fd_m));

   mux_sel_sequencer #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) u_gap (
      .clk(clk), .rst_n(rst_n), .load_valid(lv_g), .load_data(ld_g), .load_ready(lr_g),
      .mux_d(md_g), .mux_sel(ms_g), .ser_bit(sb_g), .ser_valid(sv_g),
      .frame_start(fs_g), .frame_done(fd_g));

   // Reference mux_8x1 behaviour: Y = D[S].
   function automatic logic mux_8x1(input logic [7:0] d, input logic [2:0] s);
      case (s)
         3'd0: return d[0];
         3'd1: return d[1];
         3'd2: return d[2];
         3'd3: return d[3];
         3'd4: return d[4];
         3'd5: return d[5];
         3'd6: return d[6];
         default: return d[7];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int bits_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int bits_3c [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
   int bits_c3 [8] = '{1, 1, 0, 0, 0, 0, 1, 1};

   initial begin
      rst_n = 1'b0;
      lv_a = 1'b0; ld_a = 8'h00;
      lv_m = 1'b0; ld_m = 8'h00;
      lv_g = 1'b0; ld_g = 8'h00;
      #2;
      chk("rst_ready",  32'(lr_a), 32'd1);
      chk("rst_valid",  32'(sv_a), 32'd0);
      chk("rst_mux_d",  32'(md_a), 32'h0);
      chk("rst_sel",    32'(ms_a), 32'd0);
      chk("rst_bit",    32'(sb_a), 32'd0);
      chk("rst_strobe", 32'({fs_a, fd_a}), 32'd0);
      chk("rst_ready_gap", 32'(lr_g), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single frame A5, LSB first
      ld_a = 8'hA5; lv_a = 1'b1;
      tick();
      lv_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("a5_valid", 32'(sv_a), 32'd1);
         chk("a5_sel",   32'(ms_a), 32'(i));
         chk("a5_bit",   32'(sb_a), 32'(bits_a5[i]));
         chk("a5_mux_d", 32'(md_a), 32'hA5);
         chk("a5_start", 32'(fs_a), 32'(i == 0));
         chk("a5_done",  32'(fd_a), 32'(i == 7));
         tick();
      end
      chk("a5_after_valid", 32'(sv_a), 32'd0);
      chk("a5_after_ready", 32'(lr_a), 32'd1);
      chk("a5_after_sel",   32'(ms_a), 32'd0);
      chk("a5_after_bit",   32'(sb_a), 32'd0);
      chk("a5_after_hold",  32'(md_a), 32'hA5);

      // MSB first, word 01
      ld_m = 8'h01; lv_m = 1'b1;
      tick();
      lv_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("msb_sel",   32'(ms_m), 32'(7 - i));
         chk("msb_bit",   32'(sb_m), 32'(i == 7));
         chk("msb_start", 32'(fs_m), 32'(i == 0));
         chk("msb_done",  32'(fd_m), 32'(i == 7));
         tick();
      end
      chk("msb_after_valid", 32'(sv_m), 32'd0);

      // Back-to-back FF then 00, load_valid held
      ld_a = 8'hFF; lv_a = 1'b1;
      tick();
      ld_a = 8'h00;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_valid", 32'(sv_a), 32'd1);
         chk("b2b_sel",   32'(ms_a), 32'(i % 8));
         chk("b2b_bit",   32'(sb_a), 32'(i < 8));
         chk("b2b_mux_d", 32'(md_a), (i < 8) ? 32'hFF : 32'h00);
         chk("b2b_start", 32'(fs_a), 32'((i % 8) == 0));
         chk("b2b_done",  32'(fd_a), 32'((i % 8) == 7));
         chk("b2b_ready", 32'(lr_a), 32'((i % 8) == 7));
         if (i == 8) lv_a = 1'b0;
         tick();
      end
      chk("b2b_after_valid", 32'(sv_a), 32'd0);
      chk("b2b_after_ready", 32'(lr_a), 32'd1);

      // Gap of 3 cycles, load_valid held, no word lost
      ld_g = 8'h3C; lv_g = 1'b1;
      tick();
      ld_g = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         chk("gap_f1_bit",   32'(sb_g), 32'(bits_3c[i]));
         chk("gap_f1_ready", 32'(lr_g), 32'd0);
         chk("gap_f1_done",  32'(fd_g), 32'(i == 7));
         tick();
      end
      for (int g = 0; g < 3; g++) begin
         chk("gap_valid", 32'(sv_g), 32'd0);
         chk("gap_ready", 32'(lr_g), 32'd0);
         chk("gap_sel",   32'(ms_g), 32'd0);
         tick();
      end
      chk("gap_idle_ready", 32'(lr_g), 32'd1);
      chk("gap_idle_valid", 32'(sv_g), 32'd0);
      tick();
      lv_g = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("gap_f2_mux_d", 32'(md_g), 32'hC3);
         chk("gap_f2_bit",   32'(sb_g), 32'(bits_c3[i]));
         chk("gap_f2_start", 32'(fs_g), 32'(i == 0));
         tick();
      end
      chk("gap_f2_after", 32'(sv_g), 32'd0);

      // One-hot words against the reference mux
      for (int w = 0; w < 8; w++) begin
         ld_a = 8'h01 << w; lv_a = 1'b1;
         tick();
         lv_a = 1'b0;
         for (int j = 0; j < 8; j++) begin
            chk("onehot_mux_y", 32'(mux_8x1(md_a, ms_a)), 32'(sb_a));
            chk("onehot_bit",   32'(sb_a), 32'(j == w));
            tick();
         end
      end

      // Asynchronous reset mid-frame
      ld_a = 8'h5A; lv_a = 1'b1;
      tick();
      lv_a = 1'b0;
      tick();
      tick();
      chk("mid_pre_valid", 32'(sv_a), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(sv_a), 32'd0);
      chk("mid_rst_mux_d", 32'(md_a), 32'h0);
      chk("mid_rst_sel",   32'(ms_a), 32'd0);
      chk("mid_rst_bit",   32'(sb_a), 32'd0);
      chk("mid_rst_ready", 32'(lr_a), 32'd1);
      chk("mid_rst_strb",  32'({fs_a, fd_a}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("mid_no_done",  32'(fd_a), 32'd0);
         chk("mid_no_valid", 32'(sv_a), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
